hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 228 ++++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard unit for an NLANE-wide in-order pipeline (F/D/E/M/W). It does
//   four jobs:
//   - Operand forwarding from M and W into the E stage.
//   - Load-use detection against D-stage sources.
//   - A register busy scoreboard for multi-cycle (long) operations.
//   - An ecall handshake FSM (IDLE/EWAIT) that freezes the front end until
//     the ecall has been serviced.
//   Memory waits (load miss / dirty writeback) freeze every stage.
//
// Configuration
//   HAZARD_WDOG_EN : when defined, a saturating stall watchdog counts
//                    consecutive StallF cycles and raises a sticky wdog_err
//                    once the count reaches WDOG_LIM. When undefined there
//                    is no counter and wdog_err is tied low.
//
// Ports (lane l of an NLANE*5 bus sits at [5l+4:5l])
//   clk, reset_n               clock, synchronous active-low reset
//   Rs1D/Rs2D                  D-stage source registers
//   Rs1E/Rs2E/RdE              E-stage sources and destination
//   Rs1M/Rs2M/RdM              M-stage sources and destination
//   RdW                        W-stage destination
//   enableD/enableE            D / E stage valid
//   PCSrcE                     branch taken in E
//   done_eE                    ecall serviced
//   ResultSrcE0[NLANE]         load in E
//   LongE[NLANE]               multi-cycle op in E
//   RegWriteM/RegWriteW        per-lane write enables
//   EcallM[NLANE]              ecall in M
//   Stall_miss/write_dirty     per-lane memory wait requests
//   lc_valid, lc_rd            long-op completion and its destination
//   StallF..StallW, FlushD/E/M stage stall and flush controls
//   FrowardAE/FrowardBE        per-lane E operand forward select (FW bits)
//   FrowardAM/FrowardWM        per-lane x10 ecall-result forward for M rs1/rs2
//   sb_busy[31:0]              scoreboard busy bits
//   wdog_err                   sticky stall-watchdog error
module hazard_scoreboard #(
  parameter int NLANE    = 2,
  parameter int WDOG_LIM = 1024
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [NLANE*5-1:0]                         Rs1D,
  input  logic [NLANE*5-1:0]                         Rs2D,
  input  logic [NLANE*5-1:0]                         Rs1E,
  input  logic [NLANE*5-1:0]                         Rs2E,
  input  logic [NLANE*5-1:0]                         RdE,
  input  logic [NLANE*5-1:0]                         Rs1M,
  input  logic [NLANE*5-1:0]                         Rs2M,
  input  logic [NLANE*5-1:0]                         RdM,
  input  logic [NLANE*5-1:0]                         RdW,
  input  logic                                       enableD,
  input  logic                                       enableE,
  input  logic                                       PCSrcE,
  input  logic                                       done_eE,
  input  logic [NLANE-1:0]                           ResultSrcE0,
  input  logic [NLANE-1:0]                           LongE,
  input  logic [NLANE-1:0]                           RegWriteM,
  input  logic [NLANE-1:0]                           RegWriteW,
  input  logic [NLANE-1:0]                           EcallM,
  input  logic [NLANE-1:0]                           Stall_miss,
  input  logic [NLANE-1:0]                           write_dirty,
  input  logic                                       lc_valid,
  input  logic [4:0]                                 lc_rd,
  output logic                                       StallF,
  output logic                                       StallD,
  output logic                                       StallE,
  output logic                                       StallM,
  output logic                                       StallW,
  output logic                                       FlushD,
  output logic                                       FlushE,
  output logic                                       FlushM,
  output logic [NLANE*(2+((NLANE>2)?2:1))-1:0]       FrowardAE,
  output logic [NLANE*(2+((NLANE>2)?2:1))-1:0]       FrowardBE,
  output logic [NLANE-1:0]                           FrowardAM,
  output logic [NLANE-1:0]                           FrowardWM,
  output logic [31:0]                                sb_busy,
  output logic                                       wdog_err
);

  // LW = max(1, clog2(NLANE)) for the legal range 2..4.
  localparam int LW = (NLANE > 2) ? 2 : 1;
  localparam int FW = 2 + LW;

  typedef enum logic {IDLE, EWAIT} state_t;

  state_t      state_q;
  logic [31:0] sb_busy_q, sb_busy_d;
  logic        memStall, loadHaz, sbHaz, ecallHit;
  logic        srcD10, srcE10;

  // Forward select for one source. W is scanned first and M second so that
  // a later match overrides an earlier one: M beats W, and within a stage
  // the highest lane index wins. Register 0 never forwards.
  function automatic logic [FW-1:0] fwd_sel(input logic [4:0]         rs,
                                            input logic [NLANE*5-1:0] rdm,
                                            input logic [NLANE-1:0]   wem,
                                            input logic [NLANE*5-1:0] rdw,
                                            input logic [NLANE-1:0]   wew);
    logic [FW-1:0] sel;
    sel = '0;
    if (rs != 5'd0) begin
      for (int w = 0; w < NLANE; w++)
        if (wew[w] && (rdw[w*5 +: 5] == rs)) sel = {2'b01, LW'(w)};
      for (int m = 0; m < NLANE; m++)
        if (wem[m] && (rdm[m*5 +: 5] == rs)) sel = {2'b10, LW'(m)};
    end
    return sel;
  endfunction

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    assign FrowardAE[l*FW +: FW] = fwd_sel(Rs1E[l*5 +: 5], RdM, RegWriteM, RdW, RegWriteW);
    assign FrowardBE[l*FW +: FW] = fwd_sel(Rs2E[l*5 +: 5], RdM, RegWriteM, RdW, RegWriteW);
    assign FrowardAM[l] = done_eE && (Rs1M[l*5 +: 5] == 5'd10);
    assign FrowardWM[l] = done_eE && (Rs2M[l*5 +: 5] == 5'd10);
  end

  assign memStall = (|Stall_miss) | (|write_dirty);

  // Hazard detection across every D-lane source.
  always_comb begin
    loadHaz = 1'b0;
    sbHaz   = 1'b0;
    srcD10  = 1'b0;
    srcE10  = 1'b0;
    for (int d = 0; d < NLANE; d++) begin
      for (int e = 0; e < NLANE; e++)
        if (ResultSrcE0[e] && (RdE[e*5 +: 5] != 5'd0) &&
            ((RdE[e*5 +: 5] == Rs1D[d*5 +: 5]) || (RdE[e*5 +: 5] == Rs2D[d*5 +: 5])))
          loadHaz = 1'b1;
      if (sb_busy_q[Rs1D[d*5 +: 5]] || sb_busy_q[Rs2D[d*5 +: 5]]) sbHaz = 1'b1;
      if ((Rs1D[d*5 +: 5] == 5'd10) || (Rs2D[d*5 +: 5] == 5'd10)) srcD10 = 1'b1;
      if ((Rs1E[d*5 +: 5] == 5'd10) || (Rs2E[d*5 +: 5] == 5'd10)) srcE10 = 1'b1;
    end
    loadHaz  = loadHaz & enableD;
    sbHaz    = sbHaz & enableD;
    ecallHit = (|EcallM) && ((enableD && srcD10) || (enableE && srcE10));
  end

  // Stall/flush priority: memory wait > taken branch > ecall > data hazard.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if ((state_q == EWAIT) || ecallHit) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (loadHaz || sbHaz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign StallM = memStall;
  assign StallW = memStall;

  // Completion clears first so that a new issue to the same register in the
  // same cycle keeps the bit set. x0 is never tracked.
  always_comb begin
    sb_busy_d = sb_busy_q;
    if (lc_valid) sb_busy_d[lc_rd] = 1'b0;
    if (!StallE && !FlushE)
      for (int e = 0; e < NLANE; e++)
        if (LongE[e]) sb_busy_d[RdE[e*5 +: 5]] = 1'b1;
    sb_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sb_busy_q <= '0;
    end else begin
      sb_busy_q <= sb_busy_d;
      case (state_q)
        IDLE:    if (ecallHit && !memStall) state_q <= EWAIT;
        EWAIT:   if (done_eE) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sb_busy = sb_busy_q;

`ifdef HAZARD_WDOG_EN
  localparam int CW = $clog2(WDOG_LIM + 1);

  logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_err_q, wdog_err_d;

  // The count saturates at WDOG_LIM; the error bit is sticky until reset.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (!StallF)
      wdog_cnt_d = '0;
    else if (wdog_cnt_q != CW'(WDOG_LIM))
      wdog_cnt_d = wdog_cnt_q + CW'(1);
    wdog_err_d = wdog_err_q | (wdog_cnt_d == CW'(WDOG_LIM));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NLANE = 2;
  localparam int FW    = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [9:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, Rs1M, Rs2M, RdM, RdW;
  logic             enableD, enableE, PCSrcE, done_eE;
  logic [1:0]       ResultSrcE0, LongE, RegWriteM, RegWriteW, EcallM, Stall_miss, write_dirty;
  logic             lc_valid;
  logic [4:0]       lc_rd;
  logic             StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM;
  logic [NLANE*FW-1:0] FrowardAE, FrowardBE;
  logic [1:0]       FrowardAM, FrowardWM;
  logic [31:0]      sb_busy;
  logic             wdog_err;

  int checks = 0;
  int errors = 0;

  // {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,FlushM}
  wire [7:0] st = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM};

  always #5 clk = ~clk;

  hazard_scoreboard #(.NLANE(NLANE), .WDOG_LIM(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .Rs1M(Rs1M), .Rs2M(Rs2M), .RdM(RdM), .RdW(RdW),
    .enableD(enableD), .enableE(enableE), .PCSrcE(PCSrcE), .done_eE(done_eE),
    .ResultSrcE0(ResultSrcE0), .LongE(LongE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .EcallM(EcallM), .Stall_miss(Stall_miss), .write_dirty(write_dirty),
    .lc_valid(lc_valid), .lc_rd(lc_rd),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FrowardAE(FrowardAE), .FrowardBE(FrowardBE), .FrowardAM(FrowardAM), .FrowardWM(FrowardWM),
    .sb_busy(sb_busy), .wdog_err(wdog_err)
  );

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
    Rs1M = '0; Rs2M = '0; RdM = '0; RdW = '0;
    enableD = 0; enableE = 0; PCSrcE = 0; done_eE = 0;
    ResultSrcE0 = '0; LongE = '0; RegWriteM = '0; RegWriteW = '0;
    EcallM = '0; Stall_miss = '0; write_dirty = '0;
    lc_valid = 0; lc_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    LongE = 2'b01; RdE = {5'd0, 5'd9};
    step(); step();
    LongE = '0; RdE = '0;
    #1;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL reset_sb_busy got %h exp %h", sb_busy, 32'h0); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog got %b exp 0", wdog_err); end
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL reset_stalls got %b exp %b", st, 8'b0); end
    reset_n = 1;
    step();
  endtask

  task automatic test_forward();
    clear_inputs();
    Rs1E = {5'd0, 5'd5}; RdM = {5'd5, 5'd5}; RegWriteM = 2'b11;
    #1;
    checks++; if (FrowardAE !== 6'b000_101) begin errors++; $display("FAIL fwd_m_hi_lane got %b exp %b", FrowardAE, 6'b000_101); end
    RegWriteM = 2'b01;
    #1;
    checks++; if (FrowardAE !== 6'b000_100) begin errors++; $display("FAIL fwd_m_lane0 got %b exp %b", FrowardAE, 6'b000_100); end
    RegWriteM = 2'b00; RdW = {5'd0, 5'd5}; RegWriteW = 2'b01;
    #1;
    checks++; if (FrowardAE !== 6'b000_010) begin errors++; $display("FAIL fwd_w_lane0 got %b exp %b", FrowardAE, 6'b000_010); end
    RegWriteM = 2'b10;
    #1;
    checks++; if (FrowardAE !== 6'b000_101) begin errors++; $display("FAIL fwd_m_over_w got %b exp %b", FrowardAE, 6'b000_101); end
    clear_inputs();
    Rs2E = {5'd6, 5'd0}; RdW = {5'd6, 5'd6}; RegWriteW = 2'b11; RdM = {5'd0, 5'd0}; RegWriteM = 2'b11;
    #1;
    checks++; if (FrowardBE !== 6'b011_000) begin errors++; $display("FAIL fwd_b_w_hi got %b exp %b", FrowardBE, 6'b011_000); end
    checks++; if (FrowardAE !== 6'b000_000) begin errors++; $display("FAIL fwd_x0 got %b exp %b", FrowardAE, 6'b000_000); end
    clear_inputs();
  endtask

  task automatic test_load_haz();
    clear_inputs();
    ResultSrcE0 = 2'b01; RdE = {5'd0, 5'd7}; Rs2D = {5'd7, 5'd0}; enableD = 1;
    #1;
    checks++; if (st !== 8'b11000010) begin errors++; $display("FAIL loadhaz got %b exp %b", st, 8'b11000010); end
    enableD = 0;
    #1;
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL loadhaz_noD got %b exp %b", st, 8'b0); end
    enableD = 1; RdE = '0; Rs2D = '0;
    #1;
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL loadhaz_x0 got %b exp %b", st, 8'b0); end
    clear_inputs();
    step();
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    LongE = 2'b10; RdE = {5'd9, 5'd0};
    step();
    checks++; if (sb_busy !== 32'h0000_0200) begin errors++; $display("FAIL sb_set got %h exp %h", sb_busy, 32'h200); end
    LongE = '0; RdE = '0; enableD = 1; Rs1D = {5'd0, 5'd9};
    #1;
    checks++; if (st !== 8'b11000010) begin errors++; $display("FAIL sb_stall got %b exp %b", st, 8'b11000010); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (st !== 8'b11000010) begin errors++; $display("FAIL sb_hold got %b exp %b", st, 8'b11000010); end
    end
    lc_valid = 1; lc_rd = 5'd9;
    #1;
    checks++; if (st !== 8'b11000010) begin errors++; $display("FAIL sb_lc_cycle got %b exp %b", st, 8'b11000010); end
    step();
    lc_valid = 0;
    #1;
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL sb_release got %b exp %b", st, 8'b0); end
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL sb_clear got %h exp %h", sb_busy, 32'h0); end
    // Set and clear of the same register in one cycle: set wins.
    clear_inputs();
    LongE = 2'b01; RdE = {5'd0, 5'd12}; lc_valid = 1; lc_rd = 5'd12;
    step();
    checks++; if (sb_busy !== 32'h0000_1000) begin errors++; $display("FAIL sb_set_wins got %h exp %h", sb_busy, 32'h1000); end
    LongE = '0; RdE = '0;
    step();
    lc_valid = 0;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL sb_clear12 got %h exp %h", sb_busy, 32'h0); end
    LongE = 2'b11; RdE = '0;
    step();
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL sb_x0 got %h exp %h", sb_busy, 32'h0); end
    LongE = 2'b01; RdE = {5'd0, 5'd13}; PCSrcE = 1;
    step();
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL sb_flush_block got %h exp %h", sb_busy, 32'h0); end
    clear_inputs();
    step();
  endtask

  task automatic test_ecall();
    clear_inputs();
    EcallM = 2'b01; Rs1E = {5'd0, 5'd10}; enableE = 0;
    #1;
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL ecall_noE got %b exp %b", st, 8'b0); end
    enableE = 1;
    #1;
    checks++; if (st !== 8'b11100001) begin errors++; $display("FAIL ecall_hit got %b exp %b", st, 8'b11100001); end
    step();
    EcallM = '0; Rs1E = '0; enableE = 0;
    #1;
    checks++; if (st !== 8'b11100001) begin errors++; $display("FAIL ewait1 got %b exp %b", st, 8'b11100001); end
    step();
    checks++; if (st !== 8'b11100001) begin errors++; $display("FAIL ewait2 got %b exp %b", st, 8'b11100001); end
    done_eE = 1; Rs1M = {5'd0, 5'd10}; Rs2M = {5'd10, 5'd0};
    #1;
    checks++; if (st !== 8'b11100001) begin errors++; $display("FAIL ewait_done got %b exp %b", st, 8'b11100001); end
    checks++; if (FrowardAM !== 2'b01) begin errors++; $display("FAIL fwd_am got %b exp %b", FrowardAM, 2'b01); end
    checks++; if (FrowardWM !== 2'b10) begin errors++; $display("FAIL fwd_wm got %b exp %b", FrowardWM, 2'b10); end
    step();
    done_eE = 0; Rs1M = '0; Rs2M = '0;
    #1;
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL ecall_idle got %b exp %b", st, 8'b0); end
    checks++; if (FrowardAM !== 2'b00) begin errors++; $display("FAIL fwd_am_off got %b exp %b", FrowardAM, 2'b00); end
    clear_inputs();
  endtask

  task automatic test_mem_stall();
    clear_inputs();
    Stall_miss = 2'b01; PCSrcE = 1;
    #1;
    checks++; if (st !== 8'b11111000) begin errors++; $display("FAIL memstall_branch got %b exp %b", st, 8'b11111000); end
    Stall_miss = '0; write_dirty = 2'b10; PCSrcE = 0;
    #1;
    checks++; if (st !== 8'b11111000) begin errors++; $display("FAIL dirty_stall got %b exp %b", st, 8'b11111000); end
    // Ecall seen during a memory wait must not enter EWAIT.
    EcallM = 2'b01; Rs1E = {5'd0, 5'd10}; enableE = 1;
    step();
    clear_inputs();
    #1;
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL memstall_no_ewait got %b exp %b", st, 8'b0); end
  endtask

  task automatic test_branch();
    clear_inputs();
    PCSrcE = 1; ResultSrcE0 = 2'b01; RdE = {5'd0, 5'd7}; Rs1D = {5'd0, 5'd7}; enableD = 1;
    #1;
    checks++; if (st !== 8'b00000110) begin errors++; $display("FAIL branch_over_load got %b exp %b", st, 8'b00000110); end
    EcallM = 2'b10; Rs2D = {5'd10, 5'd0};
    #1;
    checks++; if (st !== 8'b00000110) begin errors++; $display("FAIL branch_over_ecall got %b exp %b", st, 8'b00000110); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    LongE = 2'b01; RdE = {5'd0, 5'd20};
    step();
    clear_inputs();
    EcallM = 2'b01; Rs1D = {5'd0, 5'd10}; enableD = 1;
    step();
    clear_inputs();
    #1;
    checks++; if (st !== 8'b11100001) begin errors++; $display("FAIL mid_ewait got %b exp %b", st, 8'b11100001); end
    checks++; if (sb_busy !== 32'h0010_0000) begin errors++; $display("FAIL mid_busy got %h exp %h", sb_busy, 32'h0010_0000); end
    reset_n = 0;
    step();
    reset_n = 1;
    #1;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL mid_reset_busy got %h exp %h", sb_busy, 32'h0); end
    checks++; if (st !== 8'b0) begin errors++; $display("FAIL mid_reset_idle got %b exp %b", st, 8'b0); end
    step();
  endtask

  task automatic test_wdog();
    clear_inputs();
    step();
    ResultSrcE0 = 2'b01; RdE = {5'd0, 5'd7}; Rs1D = {5'd0, 5'd7}; enableD = 1;
`ifdef HAZARD_WDOG_EN
    for (int i = 0; i < 15; i++) step();
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_early got %b exp 0", wdog_err); end
    step();
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_set got %b exp 1", wdog_err); end
    clear_inputs();
    step(); step();
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b exp 1", wdog_err); end
    reset_n = 0;
    step();
    reset_n = 1;
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_reset got %b exp 0", wdog_err); end
`else
    for (int i = 0; i < 20; i++) step();
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_tied got %b exp 0", wdog_err); end
    clear_inputs();
`endif
    step();
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    #1;
    test_reset();
    test_forward();
    test_load_haz();
    test_scoreboard();
    test_ecall();
    test_mem_stall();
    test_branch();
    test_reset_mid();
    test_wdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
